// File: rtl/pie_pkg.sv
// PIE transmitter shared definitions: FSM state codes, header index
// enum and default counter width, shared with the tag-side decoder.
package pie_pkg;

  localparam int PIE_CW = 16;

  typedef logic [2:0] pie_state_t;

  localparam pie_state_t ST_IDLE   = 3'd0;
  localparam pie_state_t ST_DELIM  = 3'd1;
  localparam pie_state_t ST_HDR_HI = 3'd2;
  localparam pie_state_t ST_HDR_LO = 3'd3;
  localparam pie_state_t ST_SYM_HI = 3'd4;
  localparam pie_state_t ST_SYM_LO = 3'd5;
  localparam pie_state_t ST_END    = 3'd6;

  typedef enum logic [1:0] {
    HDR_DATA0 = 2'd0,
    HDR_RTCAL = 2'd1,
    HDR_TRCAL = 2'd2
  } pie_hdr_e;

  // Carrier level driven while in a given state.
  function automatic logic pie_level(input pie_state_t s);
    return !((s == ST_DELIM) || (s == ST_HDR_LO) ||
             (s == ST_SYM_LO));
  endfunction

endpackage

// File: rtl/pie_phase_timer.sv
// Phase down-counter: i_load arms a phase of i_len cycles (0 acts as 1),
// i_tick decrements, o_expired flags the last cycle of the phase.
module pie_phase_timer
  import pie_pkg::*;
#(
  parameter int CW = PIE_CW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_load,
  input  logic [CW-1:0] i_len,
  input  logic          i_tick,
  output logic          o_expired
);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= (i_len == '0) ? '0 : i_len - CW'(1);
    end else if (i_tick && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CW'(1);
    end
  end

  assign o_expired = (r_cnt == '0);

endmodule

// File: rtl/pie_tx.sv
// PIE frame transmitter: delimiter, header (data-0, RTcal, optional
// TRcal) then one pulse-interval symbol per streamed data bit.
// Ports: clk/reset, start+preamble+5 lengths, bit stream handshake
// (bit_in/bit_last/bit_valid/bit_ready), pie_out, busy, done, underrun.
module pie_tx
  import pie_pkg::*;
#(
  parameter int CW = PIE_CW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          preamble,
  input  logic [CW-1:0] tari_len,
  input  logic [CW-1:0] one_len,
  input  logic [CW-1:0] pw_len,
  input  logic [CW-1:0] delim_len,
  input  logic [CW-1:0] trcal_len,
  input  logic          bit_in,
  input  logic          bit_last,
  input  logic          bit_valid,
  output logic          bit_ready,
  output logic          pie_out,
  output logic          busy,
  output logic          done,
  output logic          underrun
);

  function automatic logic [CW-1:0] f_clamp(
    input logic [CW-1:0] v
  );
    return (v == '0) ? CW'(1) : v;
  endfunction

  // High phase of a symbol; never shorter than one cycle.
  function automatic logic [CW-1:0] f_hi(
    input logic [CW-1:0] l,
    input logic [CW-1:0] p
  );
    return (l > p) ? l - p : CW'(1);
  endfunction

  pie_state_t    r_state;
  pie_hdr_e      r_hdr;
  logic          r_pre;
  logic [CW-1:0] r_tari;
  logic [CW-1:0] r_one;
  logic [CW-1:0] r_pw;
  logic [CW-1:0] r_delim;
  logic [CW-1:0] r_trcal;
  logic          r_last;
  logic          r_underrun;
  logic          r_pie;

  pie_state_t    w_nstate;
  pie_hdr_e      w_nhdr;
  pie_hdr_e      w_hdr_nx;
  pie_hdr_e      w_hdr_fin;
  logic          w_load;
  logic [CW-1:0] w_len;
  logic          w_cap;
  logic          w_exp;
  logic          w_tick;
  logic [CW:0]   w_sum;
  logic [CW-1:0] w_rtcal;
  logic [CW-1:0] w_hdr_nx_len;
  logic [CW-1:0] w_bit_len;
  logic          w_hdr_end;
  logic          w_sym_end;

  assign w_sum   = {1'b0, r_tari} + {1'b0, r_one};
  assign w_rtcal = w_sum[CW] ? '1 : w_sum[CW-1:0];

  assign w_hdr_nx  = (r_hdr == HDR_DATA0) ? HDR_RTCAL : HDR_TRCAL;
  assign w_hdr_fin = r_pre ? HDR_TRCAL : HDR_RTCAL;
  assign w_hdr_nx_len =
    (w_hdr_nx == HDR_RTCAL) ? w_rtcal : r_trcal;

  assign w_bit_len = f_hi(bit_in ? r_one : r_tari, r_pw);

  assign w_hdr_end = (r_state == ST_HDR_LO) && w_exp &&
                     (r_hdr == w_hdr_fin);
  assign w_sym_end = (r_state == ST_SYM_LO) && w_exp && !r_last;

  assign bit_ready = w_hdr_end | w_sym_end;
  assign w_tick    = (r_state != ST_IDLE);

  always_comb begin
    w_nstate = r_state;
    w_nhdr   = r_hdr;
    w_load   = 1'b0;
    w_len    = '0;
    w_cap    = 1'b0;
    unique case (1'b1)
      (r_state == ST_IDLE): begin
        if (start) begin
          w_nstate = ST_DELIM;
          w_load   = 1'b1;
          w_len    = f_clamp(delim_len);
        end
      end
      (r_state == ST_DELIM): begin
        if (w_exp) begin
          w_nstate = ST_HDR_HI;
          w_nhdr   = HDR_DATA0;
          w_load   = 1'b1;
          w_len    = f_hi(r_tari, r_pw);
        end
      end
      (r_state == ST_HDR_HI),
      (r_state == ST_SYM_HI): begin
        if (w_exp) begin
          w_nstate = (r_state == ST_HDR_HI) ?
                     ST_HDR_LO : ST_SYM_LO;
          w_load   = 1'b1;
          w_len    = r_pw;
        end
      end
      (r_state == ST_HDR_LO): begin
        if (w_exp && !w_hdr_end) begin
          w_nstate = ST_HDR_HI;
          w_nhdr   = w_hdr_nx;
          w_load   = 1'b1;
          w_len    = f_hi(w_hdr_nx_len, r_pw);
        end
      end
      (r_state == ST_SYM_LO): begin
        if (w_exp && r_last) begin
          w_nstate = ST_END;
        end
      end
      (r_state == ST_END): begin
        w_nstate = ST_IDLE;
      end
      default: begin
        w_nstate = ST_IDLE;
      end
    endcase
    // Bit handoff: either start the next symbol or abort on starvation.
    if (bit_ready) begin
      if (bit_valid) begin
        w_nstate = ST_SYM_HI;
        w_load   = 1'b1;
        w_len    = w_bit_len;
        w_cap    = 1'b1;
      end else begin
        w_nstate = ST_END;
      end
    end
  end

  pie_phase_timer #(
    .CW(CW)
  ) u_timer (
    .clk       (clk),
    .reset     (reset),
    .i_load    (w_load),
    .i_len     (w_len),
    .i_tick    (w_tick),
    .o_expired (w_exp)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_hdr      <= HDR_DATA0;
      r_pre      <= 1'b0;
      r_tari     <= '0;
      r_one      <= '0;
      r_pw       <= '0;
      r_delim    <= '0;
      r_trcal    <= '0;
      r_last     <= 1'b0;
      r_underrun <= 1'b0;
      r_pie      <= 1'b1;
    end else begin
      r_state <= w_nstate;
      r_hdr   <= w_nhdr;
      r_pie   <= pie_level(w_nstate);
      if ((r_state == ST_IDLE) && start) begin
        r_pre   <= preamble;
        r_tari  <= f_clamp(tari_len);
        r_one   <= f_clamp(one_len);
        r_pw    <= f_clamp(pw_len);
        r_delim <= f_clamp(delim_len);
        r_trcal <= f_clamp(trcal_len);
      end
      if (w_cap) begin
        r_last <= bit_last;
      end
      // Frozen for the END cycle so it qualifies done.
      if (r_state != ST_END) begin
        r_underrun <= bit_ready & ~bit_valid;
      end
    end
  end

  assign pie_out  = r_pie;
  assign busy     = (r_state != ST_IDLE);
  assign done     = (r_state == ST_END);
  assign underrun = (r_state == ST_END) & r_underrun;

endmodule
